// File: rtl/matmul_trace_gen.sv
// Replays the i,j,k load/store address stream of an N x N matrix multiply onto
// a cache request port and tallies hit/miss/access statistics for the run.
//
// state | meaning
// IDLE  | waiting for start; counters hold last run's totals
// ISSUE | next access prepared; issued on the first cycle cache_ready is high
// WAIT  | enable cycle and onward; waiting for hit/miss or timeout
// DONE  | one-cycle completion pulse
module matmul_trace_gen #(
  parameter int          N          = 32,
  parameter int          ADDR_WIDTH = 32,
  parameter int          DATA_WIDTH = 32,
  parameter logic [31:0] A_BASE     = 32'h0000_0000,
  parameter logic [31:0] B_BASE     = 32'h0000_1000,
  parameter logic [31:0] C_BASE     = 32'h0000_2000,
  parameter int          TIMEOUT    = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] cache_addr,
  output logic                  cache_read_enable,
  output logic                  cache_write_enable,
  output logic [DATA_WIDTH-1:0] cache_write_data,
  input  logic                  cache_hit,
  input  logic                  cache_miss,
  input  logic                  cache_ready,
  output logic [31:0]           access_count,
  output logic [31:0]           hit_count,
  output logic [31:0]           miss_count,
  output logic                  timeout_err
);

  localparam int LOG_N = $clog2(N);
  localparam int TW    = $clog2(TIMEOUT + 1);
  localparam logic [LOG_N-1:0] IDX_LAST = LOG_N'(N - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [1:0] PH_RD_A = 2'd0;
  localparam logic [1:0] PH_RD_B = 2'd1;
  localparam logic [1:0] PH_WR_C = 2'd2;

  logic [1:0]            state;
  logic [1:0]            phase;
  logic [LOG_N-1:0]      i;
  logic [LOG_N-1:0]      j;
  logic [LOG_N-1:0]      k;
  logic [TW-1:0]         wait_cnt;
  logic [2*LOG_N-1:0]    elem;
  logic [ADDR_WIDTH-1:0] base;
  logic [ADDR_WIDTH-1:0] next_addr;
  logic [31:0]           wr_word;
  logic                  resp;
  logic                  expired;
  logic                  last_access;

  // {row, col} concatenation is row*N + col because N is a power of two
  always_comb begin
    elem = {i, k};
    base = ADDR_WIDTH'(A_BASE);
    case (phase)
      PH_RD_B: begin
        elem = {k, j};
        base = ADDR_WIDTH'(B_BASE);
      end
      PH_WR_C: begin
        elem = {i, j};
        base = ADDR_WIDTH'(C_BASE);
      end
      default: ;
    endcase
  end

  assign next_addr   = base + (ADDR_WIDTH'(elem) << 2);
  assign wr_word     = {16'(i), 16'(j)};
  assign resp        = cache_hit | cache_miss;
  assign expired     = (wait_cnt == '0);
  assign last_access = (phase == PH_WR_C) && (i == IDX_LAST) && (j == IDX_LAST);

  assign busy = (state == S_ISSUE) || (state == S_WAIT);
  assign done = (state == S_DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= S_IDLE;
      phase              <= PH_RD_A;
      i                  <= '0;
      j                  <= '0;
      k                  <= '0;
      wait_cnt           <= '0;
      cache_addr         <= '0;
      cache_read_enable  <= 1'b0;
      cache_write_enable <= 1'b0;
      cache_write_data   <= '0;
      access_count       <= '0;
      hit_count          <= '0;
      miss_count         <= '0;
      timeout_err        <= 1'b0;
    end else begin
      cache_read_enable  <= 1'b0;
      cache_write_enable <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            phase        <= PH_RD_A;
            i            <= '0;
            j            <= '0;
            k            <= '0;
            access_count <= '0;
            hit_count    <= '0;
            miss_count   <= '0;
            timeout_err  <= 1'b0;
            state        <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (cache_ready) begin
            cache_addr         <= next_addr;
            cache_read_enable  <= (phase != PH_WR_C);
            cache_write_enable <= (phase == PH_WR_C);
            cache_write_data   <= (phase == PH_WR_C) ? DATA_WIDTH'(wr_word) : '0;
            access_count       <= access_count + 32'd1;
            wait_cnt           <= TW'(TIMEOUT - 1);
            state              <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (resp || expired) begin
            // a response on the final sampled cycle still counts as a response
            if (resp) begin
              if (cache_hit) begin
                if (hit_count != '1) hit_count <= hit_count + 32'd1;
              end else if (miss_count != '1) begin
                miss_count <= miss_count + 32'd1;
              end
            end else begin
              timeout_err <= 1'b1;
            end
            case (phase)
              PH_RD_A: phase <= PH_RD_B;
              PH_RD_B: begin
                if (k == IDX_LAST) begin
                  phase <= PH_WR_C;
                end else begin
                  k     <= k + 1'b1;
                  phase <= PH_RD_A;
                end
              end
              default: begin
                phase <= PH_RD_A;
                k     <= '0;
                j     <= j + 1'b1;
                if (j == IDX_LAST) i <= i + 1'b1;
              end
            endcase
            state <= last_access ? S_DONE : S_ISSUE;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_matmul_trace_gen.sv
// Directed bench for matmul_trace_gen at N=2, TIMEOUT=8: address order, response
// handling, ready back-pressure, timeout, mid-run reset and ignored inputs.
module tb_matmul_trace_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        busy;
  logic        done;
  logic [31:0] cache_addr;
  logic        cache_read_enable;
  logic        cache_write_enable;
  logic [31:0] cache_write_data;
  logic        cache_hit = 1'b0;
  logic        cache_miss = 1'b0;
  logic        cache_ready = 1'b1;
  logic [31:0] access_count;
  logic [31:0] hit_count;
  logic [31:0] miss_count;
  logic        timeout_err;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] exp_addr [20] = '{
    32'h0000, 32'h1000, 32'h0004, 32'h1008, 32'h2000,
    32'h0000, 32'h1004, 32'h0004, 32'h100C, 32'h2004,
    32'h0008, 32'h1000, 32'h000C, 32'h1008, 32'h2008,
    32'h0008, 32'h1004, 32'h000C, 32'h100C, 32'h200C};
  logic [31:0] exp_data [20] = '{
    32'h0, 32'h0, 32'h0, 32'h0, 32'h0000_0000,
    32'h0, 32'h0, 32'h0, 32'h0, 32'h0000_0001,
    32'h0, 32'h0, 32'h0, 32'h0, 32'h0001_0000,
    32'h0, 32'h0, 32'h0, 32'h0, 32'h0001_0001};

  always #5 clk = ~clk;

  matmul_trace_gen #(.N(2), .TIMEOUT(8)) dut (
    .clk                (clk),
    .rst                (rst),
    .start              (start),
    .busy               (busy),
    .done               (done),
    .cache_addr         (cache_addr),
    .cache_read_enable  (cache_read_enable),
    .cache_write_enable (cache_write_enable),
    .cache_write_data   (cache_write_data),
    .cache_hit          (cache_hit),
    .cache_miss         (cache_miss),
    .cache_ready        (cache_ready),
    .access_count       (access_count),
    .hit_count          (hit_count),
    .miss_count         (miss_count),
    .timeout_err        (timeout_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"},  32'(busy), 0);
    chk({tag, "_done"},  32'(done), 0);
    chk({tag, "_en"},    32'({cache_read_enable, cache_write_enable}), 0);
    chk({tag, "_addr"},  cache_addr, 0);
    chk({tag, "_wdata"}, cache_write_data, 0);
    chk({tag, "_acc"},   access_count, 0);
    chk({tag, "_hit"},   hit_count, 0);
    chk({tag, "_miss"},  miss_count, 0);
    chk({tag, "_tmo"},   32'(timeout_err), 0);
  endtask

  // mode 0: hit every access; mode 1: even accesses miss (ready low 3 cycles after), odd hit
  // silent: access index left unanswered; start_mid/rst_at: access count triggering the event
  task automatic run(input string tag, input int mode, input int silent,
                     input int start_mid, input int rst_at,
                     output int n_acc, output int n_done);
    int   n = 0;
    int   first_en = -1;
    int   last_en = -1;
    int   done_cyc = -1;
    int   rlow = 0;
    logic prev_ready;
    logic prev_en = 1'b0;
    n_done = 0;
    start = 1'b1;
    for (int cyc = 1; cyc <= 400; cyc++) begin
      prev_ready = cache_ready;
      @(negedge clk);
      start      = 1'b0;
      cache_hit  = 1'b0;
      cache_miss = 1'b0;
      if (rlow > 0) begin
        rlow--;
        cache_ready = 1'b0;
      end else begin
        cache_ready = 1'b1;
      end
      if (cache_read_enable || cache_write_enable) begin
        if (first_en < 0) begin
          first_en = cyc;
          chk({tag, "_first_en_lat"}, 32'(first_en), 2);
        end
        last_en = cyc;
        if (n >= 20) begin
          chk({tag, "_extra_access"}, 32'(n), 19);
        end else begin
          chk($sformatf("%s_addr%0d", tag, n), cache_addr, exp_addr[n]);
          chk($sformatf("%s_type%0d", tag, n), 32'({cache_read_enable, cache_write_enable}),
              (n % 5 == 4) ? 32'b01 : 32'b10);
          chk($sformatf("%s_data%0d", tag, n), cache_write_data, exp_data[n]);
          chk($sformatf("%s_ready%0d", tag, n), 32'(prev_ready), 1);
          chk($sformatf("%s_gap%0d", tag, n), 32'(prev_en), 0);
        end
        if (n != silent) begin
          if (mode == 1 && (n % 2 == 0)) begin
            cache_miss  = 1'b1;
            cache_ready = 1'b0;
            rlow        = 3;
          end else begin
            cache_hit = 1'b1;
          end
        end
        n++;
        if (n == start_mid) start = 1'b1;
        if (n == rst_at) begin
          rst = 1'b1;
          @(negedge clk);
          chk_all_zero({tag, "_rst"});
          rst = 1'b0;
          cache_hit = 1'b0;
          cache_miss = 1'b0;
          cache_ready = 1'b1;
          @(negedge clk);
          chk({tag, "_rst_no_en"}, 32'({cache_read_enable, cache_write_enable}), 0);
          n_acc = n;
          return;
        end
      end
      prev_en = cache_read_enable | cache_write_enable;
      if (done) begin
        n_done++;
        done_cyc = cyc;
        chk({tag, "_busy_at_done"}, 32'(busy), 0);
        chk({tag, "_done_lat"}, 32'(done_cyc - last_en), 1);
      end
      if (done_cyc >= 0 && cyc >= done_cyc + 3) break;
    end
    if (done_cyc < 0) chk({tag, "_run_completed"}, 0, 1);
    n_acc = n;
  endtask

  initial begin
    int n_acc;
    int n_done;

    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("reset_en%0d", c), 32'({cache_read_enable, cache_write_enable}), 0);
      start       = 1'($urandom);
      cache_hit   = 1'($urandom);
      cache_miss  = 1'($urandom);
      cache_ready = 1'($urandom);
    end
    @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;
    start = 1'b0;
    cache_hit = 1'b0;
    cache_miss = 1'b0;
    cache_ready = 1'b1;
    @(negedge clk);
    chk("idle_busy", 32'(busy), 0);

    run("hit", 0, -1, -1, -1, n_acc, n_done);
    chk("hit_n", 32'(n_acc), 20);
    chk("hit_done", 32'(n_done), 1);
    chk("hit_acc", access_count, 20);
    chk("hit_hits", hit_count, 20);
    chk("hit_miss", miss_count, 0);
    chk("hit_tmo", 32'(timeout_err), 0);

    run("alt", 1, -1, -1, -1, n_acc, n_done);
    chk("alt_n", 32'(n_acc), 20);
    chk("alt_done", 32'(n_done), 1);
    chk("alt_acc", access_count, 20);
    chk("alt_hits", hit_count, 10);
    chk("alt_miss", miss_count, 10);

    run("tmo", 0, 2, -1, -1, n_acc, n_done);
    chk("tmo_n", 32'(n_acc), 20);
    chk("tmo_flag", 32'(timeout_err), 1);
    chk("tmo_acc", access_count, 20);
    chk("tmo_hits", hit_count, 19);
    chk("tmo_miss", miss_count, 0);

    run("abort", 0, -1, -1, 7, n_acc, n_done);
    chk("abort_n", 32'(n_acc), 7);
    run("rerun", 0, -1, -1, -1, n_acc, n_done);
    chk("rerun_n", 32'(n_acc), 20);
    chk("rerun_done", 32'(n_done), 1);
    chk("rerun_acc", access_count, 20);
    chk("rerun_hits", hit_count, 20);
    chk("rerun_tmo", 32'(timeout_err), 0);

    cache_hit = 1'b1;
    cache_miss = 1'b1;
    repeat (3) @(negedge clk);
    cache_hit = 1'b0;
    cache_miss = 1'b0;
    chk("idle_resp_busy", 32'(busy), 0);
    chk("idle_resp_hits", hit_count, 20);
    chk("idle_resp_miss", miss_count, 0);
    @(negedge clk);
    run("midstart", 0, -1, 5, -1, n_acc, n_done);
    chk("midstart_n", 32'(n_acc), 20);
    chk("midstart_done", 32'(n_done), 1);
    chk("midstart_acc", access_count, 20);
    chk("midstart_hits", hit_count, 20);
    chk("midstart_miss", miss_count, 0);
    repeat (4) @(negedge clk);
    chk("midstart_idle_busy", 32'(busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
